// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: syncs, blanking, data enable,
// pixel coordinates, line/frame strobes and a completed-frame counter.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 1280,
    parameter int unsigned H_FRONT   = 48,
    parameter int unsigned H_SYNC    = 112,
    parameter int unsigned H_BACK    = 248,
    parameter int unsigned V_VISIBLE = 1024,
    parameter int unsigned V_FRONT   = 1,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BACK    = 38,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0,
    parameter int unsigned CW        = 11,
    parameter int unsigned FW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          VGA_sync,
    output logic          VGA_blank,
    output logic          de,
    output logic [CW-1:0] H,
    output logic [CW-1:0] V,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_BEG = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          csync_q, csync_d, blank_q, blank_d;
    logic          ls_q, ls_d, fs_q, fs_d;
    logic          first_q, first_d;
    logic [FW-1:0] fc_q, fc_d;

    logic [31:0]   hpos, vpos;
    logic          h_vis, v_vis, h_sync_act, v_sync_act, h_wrap, v_wrap;

    // Region decode of the current counter position
    always_comb begin
        hpos       = 32'(hc_q);
        vpos       = 32'(vc_q);
        h_vis      = hpos < H_VISIBLE;
        v_vis      = vpos < V_VISIBLE;
        h_sync_act = (hpos >= H_SYNC_BEG) && (hpos < H_SYNC_END);
        v_sync_act = (vpos >= V_SYNC_BEG) && (vpos < V_SYNC_END);
        h_wrap     = hc_q == CW'(H_TOTAL - 1);
        v_wrap     = vc_q == CW'(V_TOTAL - 1);
    end

    // Next-state: advance raster and register outputs for the current pixel
    always_comb begin
        hc_d    = hc_q;
        vc_d    = vc_q;
        h_d     = h_q;
        v_d     = v_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        csync_d = csync_q;
        blank_d = blank_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        first_d = first_q;
        fc_d    = fc_q;
        if (pix_en) begin
            hc_d = h_wrap ? '0 : hc_q + CW'(1);
            if (h_wrap) begin
                vc_d = v_wrap ? '0 : vc_q + CW'(1);
            end
            h_d     = hc_q;
            v_d     = vc_q;
            hsync_d = h_sync_act ? HS_POL : ~HS_POL;
            vsync_d = v_sync_act ? VS_POL : ~VS_POL;
            csync_d = ~(h_sync_act | v_sync_act);
            blank_d = h_vis & v_vis;
            ls_d    = hc_q == '0;
            fs_d    = (hc_q == '0) && (vc_q == '0);
            // The very first (0,0) after reset opens frame 0 rather than closing one
            if (fs_d && !first_q) begin
                fc_d = fc_q + FW'(1);
            end
            first_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hc_q    <= '0;
            vc_q    <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            csync_q <= 1'b1;
            blank_q <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            first_q <= 1'b1;
            fc_q    <= '0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            csync_q <= csync_d;
            blank_q <= blank_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            first_q <= first_d;
            fc_q    <= fc_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign VGA_sync    = csync_q;
    assign VGA_blank   = blank_q;
    assign de          = blank_q;
    assign H           = h_q;
    assign V           = v_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances (small, small with
// inverted sync polarity, default timing) checked against a pixel-count model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        cs;
        logic        blank;
        logic        de;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } pix_t;

    typedef struct {
        int hv, hf, hsw, hb;
        int vv, vf, vsw, vb;
        bit hp, vp;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst_n_a  [3];
    logic        pix_en_a [3];
    logic        hs_o [3], vs_o [3], cs_o [3], blank_o [3], de_o [3], ls_o [3], fs_o [3];
    logic [10:0] h_o  [3], v_o [3];
    logic [15:0] fc_o [3];

    cfg_t cfg [3];
    pix_t sbq [3][$];
    pix_t last [3];
    int   npix [3];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(4),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(11), .FW(16)
    ) u_small (
        .clk(clk), .rst_n(rst_n_a[0]), .pix_en(pix_en_a[0]),
        .hsync(hs_o[0]), .vsync(vs_o[0]), .VGA_sync(cs_o[0]), .VGA_blank(blank_o[0]),
        .de(de_o[0]), .H(h_o[0]), .V(v_o[0]), .line_start(ls_o[0]),
        .frame_start(fs_o[0]), .frame_cnt(fc_o[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(10), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(11), .FW(16)
    ) u_pol (
        .clk(clk), .rst_n(rst_n_a[1]), .pix_en(pix_en_a[1]),
        .hsync(hs_o[1]), .vsync(vs_o[1]), .VGA_sync(cs_o[1]), .VGA_blank(blank_o[1]),
        .de(de_o[1]), .H(h_o[1]), .V(v_o[1]), .line_start(ls_o[1]),
        .frame_start(fs_o[1]), .frame_cnt(fc_o[1])
    );

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_n_a[2]), .pix_en(pix_en_a[2]),
        .hsync(hs_o[2]), .vsync(vs_o[2]), .VGA_sync(cs_o[2]), .VGA_blank(blank_o[2]),
        .de(de_o[2]), .H(h_o[2]), .V(v_o[2]), .line_start(ls_o[2]),
        .frame_start(fs_o[2]), .frame_cnt(fc_o[2])
    );

    // Reference: the n-th pixel update since reset, from raster arithmetic
    function automatic pix_t model(int d, int n);
        pix_t e;
        int ht, vt, h, v;
        bit hsa, vsa;
        ht  = cfg[d].hv + cfg[d].hf + cfg[d].hsw + cfg[d].hb;
        vt  = cfg[d].vv + cfg[d].vf + cfg[d].vsw + cfg[d].vb;
        h   = n % ht;
        v   = (n / ht) % vt;
        hsa = (h >= cfg[d].hv + cfg[d].hf) && (h < cfg[d].hv + cfg[d].hf + cfg[d].hsw);
        vsa = (v >= cfg[d].vv + cfg[d].vf) && (v < cfg[d].vv + cfg[d].vf + cfg[d].vsw);
        e.h     = 11'(h);
        e.v     = 11'(v);
        e.hs    = hsa ? cfg[d].hp : !cfg[d].hp;
        e.vs    = vsa ? cfg[d].vp : !cfg[d].vp;
        e.cs    = !(hsa || vsa);
        e.blank = (h < cfg[d].hv) && (v < cfg[d].vv);
        e.de    = e.blank;
        e.ls    = (h == 0);
        e.fs    = (h == 0) && (v == 0);
        e.fc    = 16'(n / (ht * vt));
        return e;
    endfunction

    function automatic pix_t reset_val(int d);
        pix_t e;
        e       = '0;
        e.hs    = !cfg[d].hp;
        e.vs    = !cfg[d].vp;
        e.cs    = 1'b1;
        return e;
    endfunction

    // Drive one cycle of stimulus and queue the response it should produce
    task automatic apply(input int d, input bit r, input bit p);
        pix_t e;
        rst_n_a[d]  = r;
        pix_en_a[d] = p;
        if (!r) begin
            e       = reset_val(d);
            npix[d] = 0;
        end else if (p) begin
            e       = model(d, npix[d]);
            npix[d] = npix[d] + 1;
        end else begin
            e    = last[d];
            e.ls = 1'b0;
            e.fs = 1'b0;
        end
        last[d] = e;
        sbq[d].push_back(e);
    endtask

    // Monitor: every clock each instance presents an output word to compare
    always begin
        pix_t e, a;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (sbq[d].size() > 0) begin
                e = sbq[d].pop_front();
                a = {h_o[d], v_o[d], hs_o[d], vs_o[d], cs_o[d], blank_o[d], de_o[d],
                     ls_o[d], fs_o[d], fc_o[d]};
                checks = checks + 1;
                if (a !== e) begin
                    failures = failures + 1;
                    $display("FAIL pix dut%0d t=%0t got H=%0d V=%0d hs=%b vs=%b cs=%b bl=%b de=%b ls=%b fs=%b fc=%0d want H=%0d V=%0d hs=%b vs=%b cs=%b bl=%b de=%b ls=%b fs=%b fc=%0d",
                             d, $time, a.h, a.v, a.hs, a.vs, a.cs, a.blank, a.de, a.ls, a.fs, a.fc,
                             e.h, e.v, e.hs, e.vs, e.cs, e.blank, e.de, e.ls, e.fs, e.fc);
                end
            end
        end
    end

    initial begin
        bit r0, p0, r1, p1;
        int rst_hold;
        bit trig_done;
        cfg[0] = '{8, 2, 2, 4, 4, 1, 1, 2, 1'b0, 1'b0};
        cfg[1] = '{10, 3, 4, 5, 6, 2, 2, 3, 1'b1, 1'b1};
        cfg[2] = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1'b0, 1'b0};
        for (int d = 0; d < 3; d++) begin
            rst_n_a[d]  = 1'b0;
            pix_en_a[d] = 1'b0;
            npix[d]     = 0;
            last[d]     = '0;
            assert (cfg[d].hv + cfg[d].hf + cfg[d].hsw + cfg[d].hb <= 2048)
                else $error("H_TOTAL exceeds counter range for dut%0d", d);
            assert (cfg[d].vv + cfg[d].vf + cfg[d].vsw + cfg[d].vb <= 2048)
                else $error("V_TOTAL exceeds counter range for dut%0d", d);
        end
        rst_hold  = 0;
        trig_done = 1'b0;

        for (int cyc = 0; cyc < 4500; cyc++) begin
            @(negedge clk);
            // Small config: free run, 1010 enable, mid-frame reset, then random
            if (cyc < 3) begin
                r0 = 1'b0; p0 = 1'b1;
            end else if (cyc < 303) begin
                r0 = 1'b1; p0 = 1'b1;
            end else if (cyc < 603) begin
                r0 = 1'b1; p0 = (cyc % 2) == 1;
            end else if (rst_hold > 0) begin
                r0 = 1'b0; p0 = 1'b1;
                rst_hold  = rst_hold - 1;
                trig_done = 1'b1;
            end else if (!trig_done && last[0].h == 11'd9 && last[0].v == 11'd6) begin
                r0 = 1'b0; p0 = 1'b1;
                rst_hold = 1;
            end else if (!trig_done) begin
                r0 = 1'b1; p0 = 1'b1;
            end else begin
                r0 = $urandom_range(0, 399) != 0;
                p0 = $urandom_range(0, 3) != 0;
            end
            apply(0, r0, p0);

            // Inverted polarity config: random enable with rare resets
            r1 = (cyc >= 3) && ($urandom_range(0, 599) != 0);
            p1 = $urandom_range(0, 1) == 1;
            apply(1, r1, p1);

            // Default timing: continuous run across several lines
            apply(2, cyc >= 3, 1'b1);
        end
        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < 3; d++) begin
            checks = checks + 1;
            if (sbq[d].size() != 0) begin
                failures = failures + 1;
                $display("FAIL drain dut%0d got %0d pending want 0", d, sbq[d].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/SVGA raster timing generator. It produces sync, blank, data-enable, pixel coordinates, line/frame strobes and a frame counter.
- Supersedes the fixed 1280x1024@60 sync module. All four horizontal and vertical timing segments, sync polarity and counter width are parameters.
- Adds reset, a pixel-clock enable for clk/N pixel rates, and a correctly combined composite sync.
- Sits between the pixel clock domain and the frame-buffer reader / VGA DAC.

Parameters:
- H_VISIBLE, 1280: active pixels per line
- H_FRONT, 48: horizontal front porch, pixels
- H_SYNC, 112: hsync width, pixels
- H_BACK, 248: horizontal back porch, pixels
- V_VISIBLE, 1024: active lines per frame
- V_FRONT, 1: vertical front porch, lines
- V_SYNC, 3: vsync width, lines
- V_BACK, 38: vertical back porch, lines
- HS_POL, 0: hsync active level (0 = active-low)
- VS_POL, 0: vsync active level (0 = active-low)
- CW, 11: H/V counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FW, 16: frame counter width

Ports:
- clk, in, 1: pixel-domain clock
- rst_n, in, 1: synchronous reset, active-low
- pix_en, in, 1: pixel advance enable (tie 1 for one pixel per clk)
- hsync, out, 1: horizontal sync at HS_POL level during sync segment
- vsync, out, 1: vertical sync at VS_POL level during sync segment
- VGA_sync, out, 1: composite sync, active-low; 0 when hsync or vsync segment is active
- VGA_blank, out, 1: active-low blank; 1 only inside the visible area
- de, out, 1: data enable, active-high; equals VGA_blank
- H, out, CW: horizontal position of current output pixel
- V, out, CW: vertical position of current output pixel
- line_start, out, 1: one-clk strobe when output pixel has H=0
- frame_start, out, 1: one-clk strobe when output pixel is (0,0)
- frame_cnt, out, FW: completed frames since reset, wraps

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (default 1688); V_TOTAL = sum of the four V parameters (default 1066).
- Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1) advance only on clk edges with rst_n=1 and pix_en=1.
- hc wraps H_TOTAL-1 -> 0. vc increments only on that wrap, and wraps V_TOTAL-1 -> 0.
- All outputs are registered from the same (hc,vc) in the same edge, so every output in a cycle describes the same pixel. Latency: output position = counter value before that edge's increment.
- Horizontal regions:
  - visible: [0, H_VISIBLE-1]
  - front porch: [H_VISIBLE, H_VISIBLE+H_FRONT-1]
  - sync: [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]
  - back porch: the remainder, up to H_TOTAL-1
- Vertical regions: same structure using the V parameters.
- Signal rules:
  - VGA_blank = de = (H in h-visible) AND (V in v-visible).
  - hsync = HS_POL while H is in h-sync, otherwise ~HS_POL. vsync likewise with VS_POL, depending only on V.
  - VGA_sync = NOT(h-sync active OR v-sync active). Both conditions are evaluated together; neither overrides the other.
- Strobes:
  - line_start = 1 for the update describing H=0.
  - frame_start = 1 for the update describing (0,0).
  - Both return to 0 on the next clk regardless of pix_en, so they are single-clk pulses even when pix_en is sparse.
- frame_cnt increments (mod 2^FW) on each update describing (0,0), except the first update after reset.
- pix_en=0: counters and all outputs except the strobes hold their values.
- Reset (rst_n=0 at an edge, including mid-frame) takes priority over pix_en:
  - hc=vc=0, H=V=0
  - hsync=~HS_POL, vsync=~VS_POL, VGA_sync=1
  - VGA_blank=0, de=0
  - line_start=0, frame_start=0, frame_cnt=0
- First pix_en update after reset: outputs describe (0,0), with line_start=frame_start=1, VGA_blank=1 and frame_cnt still 0.
- No parameter checking is done in RTL. The bench asserts H_TOTAL <= 2^CW and V_TOTAL <= 2^CW.

Test Plan:
- Small config (H 8/2/2/4, V 4/1/1/2, totals 16x8), pix_en=1, release reset -> H counts 0..15; hsync=0 exactly at H=10,11; VGA_blank=1 only for H 0..7 with V 0..3; line_start every 16 clks; frame_start every 128 clks.
- Same config, observe vsync -> low at V=5 for all 16 pixels of that line; VGA_sync low whenever H in {10,11} or V=5, including their overlap.
- Same config, pix_en toggled 1010... -> each position held 2 clks; strobes 1 clk wide; frame period 256 clks.
- Same config, reset asserted at (H=9, V=6) -> next edge outputs the full reset values; first update after release shows (0,0), frame_start=1, frame_cnt=0.
- Defaults, run 3 frames -> H_TOTAL=1688, V_TOTAL=1066; hsync low at H 1328..1439; vsync low at V 1025..1027; frame_cnt=3 at the start of the 4th frame.
- HS_POL=1, VS_POL=1 -> syncs high in the sync segments and low after reset; VGA_sync still active-low.
